tube_event_serializer: RTL and testbench



---
 rtl/tube_pkg.sv | 34 +++
 rtl/tube_event_serializer_slot_word_fmt.sv | 25 ++
 rtl/tube_event_serializer.sv | 118 +++++++++++
 tb/tb_tube_event_serializer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared types and constants for the tube event serializer: FSM states,
// slot tags and the slot-to-tag mapping.
package tube_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        HDR,
        SLOT
    } state_t;

    localparam logic [4:0] TAG_3A      = 5'b11000;
    localparam logic [4:0] TAG_3B      = 5'b11001;
    localparam logic [4:0] TAG_4A      = 5'b00100;
    localparam logic [4:0] TAG_4B      = 5'b00101;
    localparam logic [4:0] HDR_TAG_DEF = 5'b11111;
    localparam logic [7:0] NO_HIT      = 8'hFF;
    localparam int         NUM_SLOTS   = 32;
    localparam int         SLOT_W      = 8;

    // Each group of eight consecutive slots belongs to one tube plane.
    function automatic logic [4:0] slot_tag(input logic [4:0] slot);
        logic [4:0] tag;
        case (slot[4:3])
            2'd0:    tag = TAG_3A;
            2'd1:    tag = TAG_3B;
            2'd2:    tag = TAG_4A;
            default: tag = TAG_4B;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/tube_event_serializer_slot_word_fmt.sv
// Combinational formatter: picks one 8-bit slot out of the held record and
// builds the tagged 16-bit output word plus a no-hit flag.
module slot_word_fmt #(
    parameter int NUM_SLOTS = 32
) (
    input  logic [NUM_SLOTS*tube_pkg::SLOT_W-1:0] hold,
    input  logic [$clog2(NUM_SLOTS)-1:0]          slot,
    output logic [15:0]                           word,
    output logic                                  is_empty
);
    import tube_pkg::*;

    logic [SLOT_W-1:0] slot_bytes [NUM_SLOTS];
    logic [SLOT_W-1:0] b;

    // Slot 0 lives in the most significant byte of the record.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        assign slot_bytes[k] = hold[(NUM_SLOTS-1-k)*SLOT_W +: SLOT_W];
    end

    assign b        = slot_bytes[slot];
    assign is_empty = (b == NO_HIT);
    assign word     = {slot_tag(5'(slot)), slot[2:0], b};

endmodule

// File: rtl/tube_event_serializer.sv
// Moves 256-bit tube-timing records from the event FIFO into the 16-bit
// output FIFO as one header word followed by one tagged word per slot.
module tube_event_serializer #(
    parameter int         NUM_SLOTS  = tube_pkg::NUM_SLOTS,
    parameter bit         SKIP_EMPTY = 1'b1,
    parameter logic [4:0] HDR_TAG    = tube_pkg::HDR_TAG_DEF
) (
    input  logic                                  clk100,
    input  logic                                  rst,
    input  logic                                  ev_empty,
    output logic                                  ev_rd_en,
    input  logic [NUM_SLOTS*tube_pkg::SLOT_W-1:0] ev_dout,
    input  logic                                  out_full,
    output logic                                  out_wr_en,
    output logic [15:0]                           out_din,
    output logic                                  busy,
    output logic [15:0]                           evt_count,
    output logic [15:0]                           skip_count
);
    import tube_pkg::*;

    localparam int               IDX_W     = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);

    state_t                      state;
    state_t                      state_next;
    logic [IDX_W-1:0]            slot;
    logic [NUM_SLOTS*SLOT_W-1:0] hold;
    logic [10:0]                 seq;
    logic [15:0]                 slot_word;
    logic                        slot_is_empty;
    logic                        skip_now;
    logic                        advance;
    logic                        last_slot;

    slot_word_fmt #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_fmt (
        .hold     (hold),
        .slot     (slot),
        .word     (slot_word),
        .is_empty (slot_is_empty)
    );

    // A skipped slot never waits on out_full, so it always costs exactly one cycle.
    assign skip_now  = SKIP_EMPTY && slot_is_empty;
    assign advance   = skip_now || !out_full;
    assign last_slot = (slot == LAST_SLOT);

    always_ff @(posedge clk100) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!ev_empty) state_next = RD;
            RD:      state_next = LATCH;
            LATCH:   state_next = HDR;
            HDR:     if (!out_full) state_next = SLOT;
            SLOT:    if (advance && last_slot) state_next = ev_empty ? IDLE : RD;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are forced low while rst is high, whatever the state register holds.
    always_comb begin
        ev_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        busy      = 1'b0;
        out_din   = slot_word;
        if (state == HDR) begin
            out_din = {HDR_TAG, seq};
        end
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                RD:      ev_rd_en  = 1'b1;
                HDR:     out_wr_en = !out_full;
                SLOT:    out_wr_en = !out_full && !skip_now;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            slot       <= '0;
            hold       <= '0;
            seq        <= '0;
            evt_count  <= '0;
            skip_count <= '0;
        end else begin
            case (state)
                LATCH: begin
                    hold <= ev_dout;
                    slot <= '0;
                end
                HDR: begin
                    if (!out_full) seq <= seq + 11'd1;
                end
                SLOT: begin
                    if (skip_now) skip_count <= skip_count + 16'd1;
                    if (advance) begin
                        if (last_slot) evt_count <= evt_count + 16'd1;
                        else           slot      <= slot + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tube_event_serializer.sv
// Self-checking bench: two serializers (empty-slot skipping on and off), each
// fed by its own event FIFO model and checked against a record-level model.
module tb_tube_event_serializer;

    localparam logic [4:0] TAG_TBL [4] = '{5'b11000, 5'b11001, 5'b00100, 5'b00101};

    logic         clk100 = 1'b0;
    logic         rst = 1'b1;
    logic         out_full = 1'b0;

    logic         ev_empty_a = 1'b1;
    logic         ev_rd_en_a;
    logic [255:0] ev_dout_a = '0;
    logic         out_wr_en_a;
    logic [15:0]  out_din_a;
    logic         busy_a;
    logic [15:0]  evt_count_a;
    logic [15:0]  skip_count_a;

    logic         ev_empty_b = 1'b1;
    logic         ev_rd_en_b;
    logic [255:0] ev_dout_b = '0;
    logic         out_wr_en_b;
    logic [15:0]  out_din_b;
    logic         busy_b;
    logic [15:0]  evt_count_b;
    logic [15:0]  skip_count_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [255:0] fifo_a [$];
    logic [255:0] fifo_b [$];
    logic [15:0]  exp_a [$];
    logic [15:0]  exp_b [$];
    logic [15:0]  log_a [$];
    logic [15:0]  log_b [$];
    int           rd_cyc_a [$];
    int           wr_cyc_a [$];
    int           busy_cyc_a = 0;

    logic [10:0]  seq_a = '0;
    logic [10:0]  seq_b = '0;
    logic [15:0]  evt_exp_a = '0;
    logic [15:0]  evt_exp_b = '0;
    logic [15:0]  skip_exp_a = '0;
    logic [15:0]  skip_exp_b = '0;

    logic [255:0] rec_a;
    logic [255:0] rec_b;
    logic [15:0]  words_a [33];
    logic [15:0]  words_b [33];
    int           nw_a, ns_a, nw_b, ns_b;

    tube_event_serializer #(.NUM_SLOTS(32), .SKIP_EMPTY(1'b1), .HDR_TAG(5'b11111)) dut_a (
        .clk100     (clk100),
        .rst        (rst),
        .ev_empty   (ev_empty_a),
        .ev_rd_en   (ev_rd_en_a),
        .ev_dout    (ev_dout_a),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en_a),
        .out_din    (out_din_a),
        .busy       (busy_a),
        .evt_count  (evt_count_a),
        .skip_count (skip_count_a)
    );

    tube_event_serializer #(.NUM_SLOTS(32), .SKIP_EMPTY(1'b0), .HDR_TAG(5'b11111)) dut_b (
        .clk100     (clk100),
        .rst        (rst),
        .ev_empty   (ev_empty_b),
        .ev_rd_en   (ev_rd_en_b),
        .ev_dout    (ev_dout_b),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en_b),
        .out_din    (out_din_b),
        .busy       (busy_b),
        .evt_count  (evt_count_b),
        .skip_count (skip_count_b)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Whole-record view: header, then every slot in order unless it is a skipped no-hit.
    task automatic model_event(input logic [255:0] rec, input bit skip, input logic [10:0] seq,
                               output logic [15:0] words [33], output int n_words, output int n_skip);
        logic [7:0] b;
        n_skip   = 0;
        words[0] = {5'b11111, seq};
        n_words  = 1;
        for (int k = 0; k < 32; k++) begin
            b = 8'(rec >> (8 * (31 - k)));
            if (skip && b == 8'hFF) begin
                n_skip++;
            end else begin
                words[n_words] = {TAG_TBL[k / 8], 3'(k % 8), b};
                n_words++;
            end
        end
    endtask

    // Non-FWFT event FIFOs: data appears on ev_dout the cycle after the read strobe.
    always @(posedge clk100) begin
        if (ev_rd_en_a) begin
            checkOutput("a_rd_nonempty", 32'(fifo_a.size() != 0), 32'd1);
            if (fifo_a.size() != 0) begin
                rec_a = fifo_a.pop_front();
                ev_dout_a <= rec_a;
                model_event(rec_a, 1'b1, seq_a, words_a, nw_a, ns_a);
                for (int i = 0; i < nw_a; i++) exp_a.push_back(words_a[i]);
                seq_a      = seq_a + 11'd1;
                evt_exp_a  = evt_exp_a + 16'd1;
                skip_exp_a = skip_exp_a + 16'(ns_a);
            end
        end
        ev_empty_a <= (fifo_a.size() == 0);
    end

    always @(posedge clk100) begin
        if (ev_rd_en_b) begin
            checkOutput("b_rd_nonempty", 32'(fifo_b.size() != 0), 32'd1);
            if (fifo_b.size() != 0) begin
                rec_b = fifo_b.pop_front();
                ev_dout_b <= rec_b;
                model_event(rec_b, 1'b0, seq_b, words_b, nw_b, ns_b);
                for (int i = 0; i < nw_b; i++) exp_b.push_back(words_b[i]);
                seq_b      = seq_b + 11'd1;
                evt_exp_b  = evt_exp_b + 16'd1;
                skip_exp_b = skip_exp_b + 16'(ns_b);
            end
        end
        ev_empty_b <= (fifo_b.size() == 0);
    end

    always @(negedge clk100) begin
        if (busy_a) busy_cyc_a++;
        if (ev_rd_en_a) rd_cyc_a.push_back(cyc);
        if (out_wr_en_a) begin
            checkOutput("a_wr_while_full", 32'(out_full), 32'd0);
            log_a.push_back(out_din_a);
            wr_cyc_a.push_back(cyc);
            checkOutput("a_write_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) checkOutput("a_word", 32'(out_din_a), 32'(exp_a.pop_front()));
        end
    end

    always @(negedge clk100) begin
        if (out_wr_en_b) begin
            checkOutput("b_wr_while_full", 32'(out_full), 32'd0);
            log_b.push_back(out_din_b);
            checkOutput("b_write_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) checkOutput("b_word", 32'(out_din_b), 32'(exp_b.pop_front()));
        end
    end

    task automatic clear_model();
        fifo_a.delete(); fifo_b.delete();
        exp_a.delete();  exp_b.delete();
        log_a.delete();  log_b.delete();
        rd_cyc_a.delete(); wr_cyc_a.delete();
        busy_cyc_a = 0;
        seq_a = '0; seq_b = '0;
        evt_exp_a = '0; evt_exp_b = '0;
        skip_exp_a = '0; skip_exp_b = '0;
    endtask

    task automatic do_reset();
        @(posedge clk100); #1;
        rst = 1'b1;
        out_full = 1'b0;
        clear_model();
        repeat (2) @(posedge clk100);
        #1 rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [255:0] rec);
        @(posedge clk100); #1;
        fifo_a.push_back(rec);
        fifo_b.push_back(rec);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk100);
            if (fifo_a.size() == 0 && fifo_b.size() == 0 && !busy_a && !busy_b &&
                exp_a.size() == 0 && exp_b.size() == 0) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    // Leaves the caller at the negedge inside the header-write cycle of dut_a.
    task automatic sync_header(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk100);
            if (out_wr_en_a && out_din_a[15:11] == 5'b11111) found = 1'b1;
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    function automatic logic [255:0] make_ramp();
        logic [255:0] r = '0;
        for (int k = 0; k < 32; k++) r = (r << 8) | 256'(8'h10 + 8'(k));
        return r;
    endfunction

    function automatic logic [255:0] make_random();
        logic [255:0] r = '0;
        logic [7:0]   b;
        for (int k = 0; k < 32; k++) begin
            b = ($urandom_range(2, 0) == 0) ? 8'hFF : 8'($urandom_range(254, 0));
            r = (r << 8) | 256'(b);
        end
        return r;
    endfunction

    logic [255:0] rec2;
    int           gap;
    int           n_before;

    initial begin
        $display("[TB] reset state");
        repeat (2) @(posedge clk100);
        @(negedge clk100);
        checkOutput("rst_busy",    32'(busy_a),       32'd0);
        checkOutput("rst_rd_en",   32'(ev_rd_en_a),   32'd0);
        checkOutput("rst_wr_en",   32'(out_wr_en_a),  32'd0);
        checkOutput("rst_evt",     32'(evt_count_a),  32'd0);
        checkOutput("rst_skip",    32'(skip_count_a), 32'd0);
        @(posedge clk100); #1 rst = 1'b0;
        @(negedge clk100);
        checkOutput("idle_busy", 32'(busy_a), 32'd0);

        $display("[TB] single ramp event");
        do_reset();
        applyStimulus(make_ramp());
        wait_idle(200, "t1_idle");
        checkOutput("t1_b_count",  32'(log_b.size()), 32'd33);
        checkOutput("t1_b_hdr",    32'(log_b[0]),     32'h0000F800);
        checkOutput("t1_b_slot9",  32'(log_b[10]),    32'h0000C919);
        checkOutput("t1_b_slot31", 32'(log_b[32]),    32'h00002F2F);
        checkOutput("t1_b_evt",    32'(evt_count_b),  32'd1);
        checkOutput("t1_a_count",  32'(log_a.size()), 32'd33);

        $display("[TB] sparse event");
        do_reset();
        rec2 = '1;
        rec2[255 -: 8] = 8'h05;
        rec2[255 - 8*20 -: 8] = 8'h42;
        applyStimulus(rec2);
        wait_idle(200, "t2_idle");
        checkOutput("t2_a_count", 32'(log_a.size()),  32'd3);
        checkOutput("t2_a_w0",    32'(log_a[0]),      32'h0000F800);
        checkOutput("t2_a_w1",    32'(log_a[1]),      32'h0000C005);
        checkOutput("t2_a_w2",    32'(log_a[2]),      32'h00002442);
        checkOutput("t2_a_skip",  32'(skip_count_a),  32'd30);
        checkOutput("t2_b_count", 32'(log_b.size()),  32'd33);
        checkOutput("t2_b_skip",  32'(skip_count_b),  32'd0);

        $display("[TB] output stall at slot 5");
        do_reset();
        applyStimulus(make_ramp());
        sync_header("t3_hdr_seen");
        repeat (6) @(posedge clk100);
        #1 out_full = 1'b1;
        n_before = log_a.size();
        checkOutput("t3_pre_stall", 32'(n_before), 32'd6);
        repeat (10) @(posedge clk100);
        #1;
        checkOutput("t3_stall_nowr", 32'(log_a.size()), 32'(n_before));
        out_full = 1'b0;
        wait_idle(200, "t3_idle");
        checkOutput("t3_a_count", 32'(log_a.size()), 32'd33);
        checkOutput("t3_slot5",   32'(log_a[6]),     32'h0000C515);
        checkOutput("t3_slot6",   32'(log_a[7]),     32'h0000C616);
        checkOutput("t3_b_count", 32'(log_b.size()), 32'd33);

        $display("[TB] three back-to-back events");
        do_reset();
        applyStimulus(make_ramp());
        applyStimulus(make_ramp());
        applyStimulus(make_ramp());
        wait_idle(400, "t4_idle");
        checkOutput("t4_rd_pulses", 32'(rd_cyc_a.size()), 32'd3);
        checkOutput("t4_rd_gap1",   32'(rd_cyc_a[1] - rd_cyc_a[0]), 32'd35);
        checkOutput("t4_rd_gap2",   32'(rd_cyc_a[2] - rd_cyc_a[1]), 32'd35);
        checkOutput("t4_busy_cyc",  32'(busy_cyc_a), 32'd105);
        checkOutput("t4_hdr_lat",   32'(wr_cyc_a[0] - rd_cyc_a[0]), 32'd2);
        checkOutput("t4_hdr0",      32'(log_a[0]),  32'h0000F800);
        checkOutput("t4_hdr1",      32'(log_a[33]), 32'h0000F801);
        checkOutput("t4_hdr2",      32'(log_a[66]), 32'h0000F802);
        checkOutput("t4_evt",       32'(evt_count_a), 32'd3);

        $display("[TB] reset mid-event");
        do_reset();
        applyStimulus(make_ramp());
        sync_header("t5_hdr_seen");
        repeat (13) @(posedge clk100);
        #1;
        checkOutput("t5_partial", 32'(log_a.size()), 32'd13);
        rst = 1'b1;
        clear_model();
        @(negedge clk100);
        checkOutput("t5_rst_wr_a", 32'(out_wr_en_a), 32'd0);
        checkOutput("t5_rst_wr_b", 32'(out_wr_en_b), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy_a),      32'd0);
        @(posedge clk100); #1 rst = 1'b0;
        @(negedge clk100);
        checkOutput("t5_idle",     32'(busy_a),      32'd0);
        checkOutput("t5_evt_zero", 32'(evt_count_a), 32'd0);
        applyStimulus(make_ramp());
        wait_idle(200, "t5_idle_after");
        checkOutput("t5_hdr",   32'(log_a[0]),    32'h0000F800);
        checkOutput("t5_evt",   32'(evt_count_a), 32'd1);

        $display("[TB] all-empty event");
        do_reset();
        applyStimulus('1);
        wait_idle(200, "t6_idle");
        checkOutput("t6_a_count", 32'(log_a.size()), 32'd1);
        checkOutput("t6_a_hdr",   32'(log_a[0]),     32'h0000F800);
        checkOutput("t6_a_skip",  32'(skip_count_a), 32'd32);
        checkOutput("t6_a_evt",   32'(evt_count_a),  32'd1);
        checkOutput("t6_b_count", 32'(log_b.size()), 32'd33);
        checkOutput("t6_b_last",  32'(log_b[32]),    32'h00002FFF);

        $display("[TB] randomized events with random back-pressure");
        do_reset();
        for (int e = 0; e < 8; e++) begin
            applyStimulus(make_random());
            gap = $urandom_range(40, 0);
            for (int c = 0; c < gap; c++) begin
                @(posedge clk100); #1;
                out_full = ($urandom_range(3, 0) == 0);
            end
        end
        @(posedge clk100); #1 out_full = 1'b0;
        wait_idle(2000, "rand_idle");
        checkOutput("rand_a_evt",  32'(evt_count_a),  32'(evt_exp_a));
        checkOutput("rand_a_skip", 32'(skip_count_a), 32'(skip_exp_a));
        checkOutput("rand_b_evt",  32'(evt_count_b),  32'(evt_exp_b));
        checkOutput("rand_b_skip", 32'(skip_count_b), 32'(skip_exp_b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
